// File: rtl/wishbone_burst_slave_mem.sv
// Wishbone B4 slave backed by a word memory, with classic, linear-burst and
// wrap-burst support, optional wait states and an error-beat counter.
module wishbone_burst_slave_mem #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [ADDR_WIDTH-1:0]   wbs_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  input  logic [DATA_WIDTH/8-1:0] wbs_sel_i,
  input  logic [2:0]              wbs_cti_i,
  input  logic [1:0]              wbs_bte_i,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  output logic                    wbs_ack_o,
  output logic                    wbs_err_o,
  output logic                    busy_o,
  output logic [15:0]             err_count_o
);

  localparam int                    LP_IDX_W     = $clog2(DEPTH_WORDS);
  localparam int                    LP_LANES     = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   LP_SPAN      = (ADDR_WIDTH + 1)'(DEPTH_WORDS * 4);
  localparam logic [3:0]            LP_WAIT_LAST = 4'((WAIT_STATES == 0) ? 0 : (WAIT_STATES - 1));
  localparam logic [LP_IDX_W-1:0]   LP_LAST_IDX  = LP_IDX_W'(DEPTH_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_BEAT = 2'b10,
    ST_ERR  = 2'b11
  } state_t;

  state_t                r_state;
  logic [LP_IDX_W-1:0]   r_idx;
  logic [3:0]            r_wait_cnt;
  logic                  r_ack;
  logic                  r_err;
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] r_dat;
  logic [15:0]           r_err_count;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

  logic                  w_req;
  logic                  w_in_range;
  logic                  w_burst;
  logic                  w_burst_ovf;
  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_off;
  logic [LP_IDX_W-1:0]   w_adr_idx;
  logic [LP_IDX_W-1:0]   w_burst_idx;

  // Wrap-N keeps the upper index bits and increments only inside the aligned block.
  function automatic logic [LP_IDX_W-1:0] f_next_idx(input logic [LP_IDX_W-1:0] idx,
                                                    input logic [1:0]          bte);
    logic [LP_IDX_W-1:0] v_mask;
    logic [LP_IDX_W-1:0] v_inc;
    v_inc = idx + LP_IDX_W'(1);
    case (bte)
      2'b01:   v_mask = LP_IDX_W'(3);
      2'b10:   v_mask = LP_IDX_W'(7);
      2'b11:   v_mask = LP_IDX_W'(15);
      default: v_mask = '0;
    endcase
    if (bte == 2'b00) begin
      return v_inc;
    end else begin
      return (idx & ~v_mask) | (v_inc & v_mask);
    end
  endfunction

  function automatic logic [15:0] f_sat_inc(input logic [15:0] cnt);
    if (cnt == 16'hFFFF) begin
      return cnt;
    end else begin
      return cnt + 16'd1;
    end
  endfunction

  // Address decode and burst-continuation helpers.
  always_comb begin
    w_req       = wbs_cyc_i & wbs_stb_i;
    w_off       = wbs_adr_i - BASE_ADDR;
    w_in_range  = (wbs_adr_i >= BASE_ADDR) && ({1'b0, w_off} < LP_SPAN) &&
                  (wbs_adr_i[1:0] == 2'b00);
    w_adr_idx   = w_off[LP_IDX_W+1:2];
    w_burst     = w_req && (wbs_cti_i == 3'b010);
    w_burst_ovf = (wbs_bte_i == 2'b00) && (r_idx == LP_LAST_IDX);
    w_burst_idx = f_next_idx(r_idx, wbs_bte_i);
    w_wr_en     = (r_state == ST_BEAT) && w_req && wbs_we_i;
  end

  // Bus FSM; every output is a register updated together with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_wait_cnt  <= 4'd0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_dat       <= '0;
      r_err_count <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ack <= 1'b0;
          r_err <= 1'b0;
          r_dat <= '0;
          if (w_req && w_in_range) begin
            r_idx      <= w_adr_idx;
            r_wait_cnt <= 4'd0;
            r_busy     <= 1'b1;
            if (WAIT_STATES > 0) begin
              r_state <= ST_WAIT;
            end else begin
              r_state <= ST_BEAT;
              r_ack   <= 1'b1;
              r_dat   <= r_mem[w_adr_idx];
            end
          end else if (w_req) begin
            r_state     <= ST_ERR;
            r_err       <= 1'b1;
            r_busy      <= 1'b1;
            r_err_count <= f_sat_inc(r_err_count);
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (!w_req) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_wait_cnt <= 4'd0;
          end else if (r_wait_cnt == LP_WAIT_LAST) begin
            r_state    <= ST_BEAT;
            r_ack      <= 1'b1;
            r_dat      <= r_mem[r_idx];
            r_wait_cnt <= 4'd0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
          end
        end
        ST_BEAT: begin
          if (w_burst && w_burst_ovf) begin
            // Linear burst ran off the end of memory: error the next beat.
            r_state     <= ST_ERR;
            r_ack       <= 1'b0;
            r_err       <= 1'b1;
            r_dat       <= '0;
            r_err_count <= f_sat_inc(r_err_count);
          end else if (w_burst) begin
            r_state <= ST_BEAT;
            r_idx   <= w_burst_idx;
            r_ack   <= 1'b1;
            r_dat   <= r_mem[w_burst_idx];
          end else begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_dat   <= '0;
          end
        end
        ST_ERR: begin
          r_state <= ST_IDLE;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_ack      <= 1'b0;
          r_err      <= 1'b0;
          r_busy     <= 1'b0;
          r_dat      <= '0;
          r_wait_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Byte-lane write on the edge that completes a write beat; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int l = 0; l < LP_LANES; l++) begin
        if (wbs_sel_i[l]) begin
          r_mem[r_idx][l*8 +: 8] <= wbs_dat_i[l*8 +: 8];
        end
      end
    end
  end

  assign wbs_ack_o   = r_ack;
  assign wbs_err_o   = r_err;
  assign wbs_dat_o   = r_dat;
  assign busy_o      = r_busy;
  assign err_count_o = r_err_count;

endmodule

// File: tb/tb_wishbone_burst_slave_mem.sv
// Directed self-checking bench: one zero-wait-state instance for the main
// features and a three-wait-state instance for latency and abort behaviour.
module tb_wishbone_burst_slave_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cyc0 = 1'b0, stb0 = 1'b0, cyc3 = 1'b0, stb3 = 1'b0;
  logic        we = 1'b0;
  logic [31:0] adr = 32'd0;
  logic [31:0] dat = 32'd0;
  logic [3:0]  sel = 4'd0;
  logic [2:0]  cti = 3'd0;
  logic [1:0]  bte = 2'd0;

  logic [31:0] dat_o0, dat_o3;
  logic        ack0, ack3, err0, err3, busy0, busy3;
  logic [15:0] cnt0, cnt3;

  logic [31:0] wdata [16];
  logic [31:0] rdata [16];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  wishbone_burst_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(256),
                             .BASE_ADDR(32'd0), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .wbs_cyc_i(cyc0), .wbs_stb_i(stb0), .wbs_we_i(we),
    .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_sel_i(sel), .wbs_cti_i(cti), .wbs_bte_i(bte),
    .wbs_dat_o(dat_o0), .wbs_ack_o(ack0), .wbs_err_o(err0), .busy_o(busy0),
    .err_count_o(cnt0));

  wishbone_burst_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(256),
                             .BASE_ADDR(32'd0), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst(rst), .wbs_cyc_i(cyc3), .wbs_stb_i(stb3), .wbs_we_i(we),
    .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_sel_i(sel), .wbs_cti_i(cti), .wbs_bte_i(bte),
    .wbs_dat_o(dat_o3), .wbs_ack_o(ack3), .wbs_err_o(err3), .busy_o(busy3),
    .err_count_o(cnt3));

  // Bus master: drives after the rising edge, samples on the falling edge.
  task automatic wb_burst(input logic inst3, input logic w, input logic [31:0] a,
                          input int n, input logic [1:0] b, input logic [3:0] s,
                          input int rst_at, output int n_ack, output int n_err,
                          output int first_lat, output int gaps);
    int   beat = 0;
    int   pe = 0;
    logic done = 1'b0;
    logic aborted = 1'b0;
    logic sa, se;
    logic [31:0] sd;
    n_ack = 0; n_err = 0; first_lat = -1; gaps = 0;
    @(posedge clk); #1;
    if (inst3) begin cyc3 = 1'b1; stb3 = 1'b1; end
    else begin cyc0 = 1'b1; stb0 = 1'b1; end
    we = w; adr = a; sel = s; bte = b; dat = wdata[0];
    cti = (n > 1) ? 3'b010 : 3'b000;
    while (!done && pe < 40) begin
      @(negedge clk);
      sa = inst3 ? ack3 : ack0;
      se = inst3 ? err3 : err0;
      sd = inst3 ? dat_o3 : dat_o0;
      if (se) begin
        n_err++;
        done = 1'b1;
      end else if (sa) begin
        if (first_lat < 0) first_lat = pe;
        rdata[beat] = sd;
        if (beat == rst_at) begin
          rst = 1'b0;
          #1;
          aborted = 1'b1;
        end
        n_ack++;
        beat++;
        if (beat == n) done = 1'b1;
      end else if (first_lat >= 0) begin
        gaps++;
      end
      if (aborted) begin
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
        pe++;
        if (!done) begin
          dat = wdata[beat];
          if (n > 1) cti = (beat == n - 1) ? 3'b111 : 3'b010;
        end
      end
    end
    cyc0 = 1'b0; stb0 = 1'b0; cyc3 = 1'b0; stb3 = 1'b0;
    cti = 3'b000; bte = 2'b00;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", ack0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err0); end
    checks++; if (dat_o0 !== 32'd0) begin errors++; $display("FAIL reset_dat: got %h expected 0", dat_o0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy0); end
    checks++; if (cnt0 !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt0); end
    rst = 1'b1;
  endtask

  task automatic test_classic();
    int na, ne, lat, g;
    wdata[0] = 32'hDEADBEEF;
    wb_burst(1'b0, 1'b1, 32'h10, 1, 2'b00, 4'hF, -1, na, ne, lat, g);
    checks++; if (na !== 1 || ne !== 0) begin errors++; $display("FAIL classic_wr_acks: got ack=%0d err=%0d expected 1/0", na, ne); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL classic_wr_latency: got %0d expected 1", lat); end
    wb_burst(1'b0, 1'b0, 32'h10, 1, 2'b00, 4'hF, -1, na, ne, lat, g);
    checks++; if (na !== 1) begin errors++; $display("FAIL classic_rd_acks: got %0d expected 1", na); end
    checks++; if (rdata[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL classic_rd_data: got %h expected deadbeef", rdata[0]); end
    wdata[0] = 32'h11223344;
    wb_burst(1'b0, 1'b1, 32'h10, 1, 2'b00, 4'b0101, -1, na, ne, lat, g);
    wb_burst(1'b0, 1'b0, 32'h10, 1, 2'b00, 4'hF, -1, na, ne, lat, g);
    checks++; if (rdata[0] !== 32'hDE22BE44) begin errors++; $display("FAIL byte_lanes: got %h expected de22be44", rdata[0]); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    cyc0 = 1'b1; stb0 = 1'b1; we = 1'b1; adr = 32'h40; dat = 32'h12345678; sel = 4'hF; cti = 3'b000;
    @(negedge clk);
    @(negedge clk);
    checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL b2b_first_ack: got %b expected 1", ack0); end
    @(posedge clk); #1;
    we = 1'b0;
    @(negedge clk);
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL b2b_ack_gap: got %b expected 0", ack0); end
    @(negedge clk);
    checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL b2b_second_ack: got %b expected 1", ack0); end
    checks++; if (dat_o0 !== 32'h12345678) begin errors++; $display("FAIL b2b_data: got %h expected 12345678", dat_o0); end
    @(posedge clk); #1;
    cyc0 = 1'b0; stb0 = 1'b0;
  endtask

  task automatic test_burst_linear();
    int na, ne, lat, g;
    for (int k = 0; k < 8; k++) wdata[k] = 32'hA0000000 + 32'(k) * 32'h111;
    wb_burst(1'b0, 1'b1, 32'h20, 8, 2'b00, 4'hF, -1, na, ne, lat, g);
    checks++; if (na !== 8 || g !== 0) begin errors++; $display("FAIL lin_wr: got acks=%0d gaps=%0d expected 8/0", na, g); end
    wb_burst(1'b0, 1'b0, 32'h20, 8, 2'b00, 4'hF, -1, na, ne, lat, g);
    checks++; if (na !== 8 || g !== 0) begin errors++; $display("FAIL lin_rd: got acks=%0d gaps=%0d expected 8/0", na, g); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (rdata[k] !== 32'hA0000000 + 32'(k) * 32'h111) begin
        errors++; $display("FAIL lin_rd_data[%0d]: got %h expected %h", k, rdata[k], 32'hA0000000 + 32'(k) * 32'h111);
      end
    end
  endtask

  task automatic test_wrap();
    int na, ne, lat, g;
    int exp4 [4] = '{6, 7, 4, 5};
    int exp8 [8] = '{3, 4, 5, 6, 7, 0, 1, 2};
    wb_burst(1'b0, 1'b0, 32'h38, 4, 2'b01, 4'hF, -1, na, ne, lat, g);
    checks++; if (na !== 4) begin errors++; $display("FAIL wrap4_acks: got %0d expected 4", na); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rdata[k] !== 32'hA0000000 + 32'(exp4[k]) * 32'h111) begin
        errors++; $display("FAIL wrap4_data[%0d]: got %h expected %h", k, rdata[k], 32'hA0000000 + 32'(exp4[k]) * 32'h111);
      end
    end
    wb_burst(1'b0, 1'b0, 32'h2C, 8, 2'b10, 4'hF, -1, na, ne, lat, g);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (rdata[k] !== 32'hA0000000 + 32'(exp8[k]) * 32'h111) begin
        errors++; $display("FAIL wrap8_data[%0d]: got %h expected %h", k, rdata[k], 32'hA0000000 + 32'(exp8[k]) * 32'h111);
      end
    end
  endtask

  task automatic test_errors();
    int na, ne, lat, g;
    wb_burst(1'b0, 1'b0, 32'h5, 1, 2'b00, 4'hF, -1, na, ne, lat, g);
    checks++; if (na !== 0 || ne !== 1) begin errors++; $display("FAIL err_misaligned: got ack=%0d err=%0d expected 0/1", na, ne); end
    checks++; if (cnt0 !== 16'd1) begin errors++; $display("FAIL err_count1: got %0d expected 1", cnt0); end
    wb_burst(1'b0, 1'b0, 32'h400, 1, 2'b00, 4'hF, -1, na, ne, lat, g);
    checks++; if (na !== 0 || ne !== 1) begin errors++; $display("FAIL err_range: got ack=%0d err=%0d expected 0/1", na, ne); end
    checks++; if (cnt0 !== 16'd2) begin errors++; $display("FAIL err_count2: got %0d expected 2", cnt0); end
    wdata[0] = 32'h0BADF00D; wdata[1] = 32'h0BADF00E;
    wb_burst(1'b0, 1'b1, 32'h3FC, 2, 2'b00, 4'hF, -1, na, ne, lat, g);
    checks++; if (na !== 1 || ne !== 1) begin errors++; $display("FAIL err_overrun: got ack=%0d err=%0d expected 1/1", na, ne); end
    checks++; if (cnt0 !== 16'd3) begin errors++; $display("FAIL err_count3: got %0d expected 3", cnt0); end
    @(negedge clk);
    checks++; if (err0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL err_recover: got err=%b busy=%b expected 0/0", err0, busy0); end
  endtask

  task automatic test_wait_states();
    int na, ne, lat, g;
    logic seen_ack = 1'b0;
    wdata[0] = 32'hCAFEF00D;
    wb_burst(1'b1, 1'b1, 32'h0, 1, 2'b00, 4'hF, -1, na, ne, lat, g);
    checks++; if (lat !== 4) begin errors++; $display("FAIL ws_wr_latency: got %0d expected 4", lat); end
    wb_burst(1'b1, 1'b0, 32'h0, 1, 2'b00, 4'hF, -1, na, ne, lat, g);
    checks++; if (lat !== 4 || rdata[0] !== 32'hCAFEF00D) begin errors++; $display("FAIL ws_rd: got lat=%0d data=%h expected 4/cafef00d", lat, rdata[0]); end
    @(posedge clk); #1;
    cyc3 = 1'b1; stb3 = 1'b1; we = 1'b0; adr = 32'h0; cti = 3'b000;
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy3 !== 1'b1 || ack3 !== 1'b0) begin errors++; $display("FAIL ws_in_wait: got busy=%b ack=%b expected 1/0", busy3, ack3); end
    @(posedge clk); #1;
    cyc3 = 1'b0; stb3 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL ws_abort_busy: got %b expected 0", busy3); end
    repeat (5) begin
      @(negedge clk);
      if (ack3 === 1'b1) seen_ack = 1'b1;
    end
    checks++; if (seen_ack !== 1'b0) begin errors++; $display("FAIL ws_abort_noack: got ack seen=%b expected 0", seen_ack); end
  endtask

  task automatic test_reset_mid_burst();
    int na, ne, lat, g;
    for (int k = 0; k < 8; k++) wdata[k] = 32'h55000000 + 32'(k);
    wb_burst(1'b0, 1'b1, 32'h0, 8, 2'b00, 4'hF, -1, na, ne, lat, g);
    for (int k = 0; k < 8; k++) wdata[k] = 32'h77000000 + 32'(k);
    wb_burst(1'b0, 1'b1, 32'h0, 8, 2'b00, 4'hF, 3, na, ne, lat, g);
    checks++; if (ack0 !== 1'b0 || err0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl: got ack=%b err=%b busy=%b expected 0/0/0", ack0, err0, busy0); end
    checks++; if (dat_o0 !== 32'd0 || cnt0 !== 16'd0) begin errors++; $display("FAIL rst_mid_data: got dat=%h cnt=%0d expected 0/0", dat_o0, cnt0); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    wb_burst(1'b0, 1'b0, 32'h0, 8, 2'b00, 4'hF, -1, na, ne, lat, g);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (rdata[k] !== ((k < 3) ? 32'h77000000 + 32'(k) : 32'h55000000 + 32'(k))) begin
        errors++; $display("FAIL rst_mid_word[%0d]: got %h expected %h", k, rdata[k],
                           (k < 3) ? 32'h77000000 + 32'(k) : 32'h55000000 + 32'(k));
      end
    end
  endtask

  initial begin
    test_reset();
    test_classic();
    test_back_to_back();
    test_burst_linear();
    test_wrap();
    test_errors();
    test_wait_states();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
